// File: rtl/uart_tx_buf.sv
// uart_tx_buf: FIFO-buffered UART transmitter (start bit, DBIT data bits LSB first, optional parity, STOP_BITS stop bits).
// Latency: tx_en at cycle N into an empty FIFO with the FSM idle drives the start bit from cycle N+2.
// Backpressure: tx_en is dropped while fifo_full=1; queued words leave back-to-back with no idle gap.
// Optional feature: define UART_PARITY_EN to insert a parity bit (sense chosen by PARITY_ODD).
module uart_tx_buf #(
  parameter int DBIT         = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DBIT-1:0] din,
  input  logic            tx_en,
  output logic            tx,
  output logic            tx_done_tick,
  output logic            fifo_full,
  output logic            fifo_empty,
  output logic            busy
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DBIT + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // Parameter sanity: reject configurations the datapath is not sized for.
  if (DBIT < 5 || DBIT > 9) begin : g_bad_dbit
    $error("uart_tx_buf: DBIT must be in 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_buf: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_buf: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_buf: FIFO_DEPTH must be a power of 2, >= 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_tx_buf: PARITY_ODD must be 0 or 1");
  end

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // ---------------- transmit FIFO ----------------
  logic [DBIT-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [DBIT-1:0]  head;
  logic             push;
  logic             pop;

  // A full FIFO drops the write even when a pop frees a slot this cycle.
  assign push = tx_en & ~fifo_full;
  assign head = mem[rd_ptr];

  // Occupancy after this cycle's push/pop; full/empty are registered from it.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      fifo_empty <= (count_next == '0);
      fifo_full  <= (count_next == CNT_W'(FIFO_DEPTH));
    end
  end

  // Storage write; din is captured here so later changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // ---------------- serialiser ----------------
  state_t            state;
  state_t            state_next;
  logic [TICK_W-1:0] tick_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DBIT-1:0]   shreg;
  logic              tick_last;
  logic              data_last;
  logic              stop_last;
`ifdef UART_PARITY_EN
  logic              parity_bit;
`endif

  assign tick_last = (tick_cnt == TICK_W'(CLKS_PER_BIT - 1));
  assign data_last = tick_last && (bit_cnt == BIT_W'(DBIT - 1));
  assign stop_last = tick_last && (bit_cnt == BIT_W'(STOP_BITS - 1));
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state, line level, pop request and completion pulse.
  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    tx           = 1'b1;
    tx_done_tick = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (tick_last) state_next = DATA;
      end
      DATA: begin
        tx = shreg[0];
`ifdef UART_PARITY_EN
        if (data_last) state_next = PARITY;
`else
        if (data_last) state_next = STOP;
`endif
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        tx = parity_bit;
        if (tick_last) state_next = STOP;
      end
`endif
      STOP: begin
        if (stop_last) begin
          tx_done_tick = 1'b1;
          // Chain straight into the next frame when data is waiting.
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit-cycle and bit counters; both return to zero on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (state == IDLE || tick_last) tick_cnt <= '0;
      else                            tick_cnt <= tick_cnt + 1'b1;
      if (state_next != state) bit_cnt <= '0;
      else if (tick_last)      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Shift register loads the FIFO head on pop and shifts right after each data bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
    end else if (pop) begin
      shreg <= head;
    end else if (state == DATA && tick_last) begin
      shreg <= shreg >> 1;
    end
  end

`ifdef UART_PARITY_EN
  // Parity is taken from the whole word at load time, before shifting destroys it.
  always_ff @(posedge clk) begin
    if (reset)    parity_bit <= 1'b0;
    else if (pop) parity_bit <= (^head) ^ (PARITY_ODD != 0);
  end
`endif

endmodule
